rf2p_arbiter: RTL and testbench
===============================

# rf2p_arbiter

Round-robin arbiter that shares one two-port register file (independent read and write ports) among `NREQ` requesters. It sits between the compute-side clients and a single RF2P instance. The read and write ports are arbitrated independently each cycle. The block returns read data one cycle after grant, tagged to the winning requester, and resolves same-address read/write collisions.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; minimum 2.
- `DWd`, 16: data width.
- `AWd`, 5: address width.

Ports:
- `i_clk`  in  1  sole clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, synchronous and active-high.
- `i_rreq`  in  NREQ  per-requester read request.
- `i_raddr`  in  NREQ×AWd  per-requester read address.
- `o_rgnt`  out  NREQ  one-hot read grant, combinational, same cycle as request.
- `o_rvalid`  out  NREQ  one-hot read-data valid, registered.
- `o_rdata`  out  DWd  shared read data, qualified by `o_rvalid`.
- `i_wreq`  in  NREQ  per-requester write request.
- `i_waddr`  in  NREQ×AWd  per-requester write address.
- `i_wdata`  in  NREQ×DWd  per-requester write data.
- `o_wgnt`  out  NREQ  one-hot write grant, combinational.
- `o_rf_read`, `o_rf_raddr`  out  1, AWd  RF read command.
- `i_rf_rdata`  in  DWd  RF read data, valid one cycle after `o_rf_read`.
- `o_rf_write`, `o_rf_waddr`, `o_rf_wdata`  out  1, AWd, DWd  RF write command.

## Operation
- **Request handshake**
  - A requester holds its request, address and data stable until it sees its grant.
  - A grant completes the transfer in that cycle.
  - A requester may drop its request without being granted.
- **Read arbitration**
  - Round-robin over `i_rreq`, starting at pointer `rptr` (`clog2(NREQ)` bits).
  - The first asserted request at or above `rptr`, wrapping modulo `NREQ`, wins.
  - On a grant, `rptr` ← winner+1 (wrapping to 0 after `NREQ-1`). With no grant, `rptr` holds.
- **Write arbitration**: identical, with its own pointer `wptr`, independent of reads.
- **RF command**
  - `o_rf_read` = OR of `o_rgnt`; `o_rf_raddr` = winner's address.
  - Write side likewise.
  - When there is no grant, the address and data outputs are 0.
- **Read return**
  - The winner's one-hot is registered into `o_rvalid`.
  - `o_rdata` = `i_rf_rdata` during the cycle `o_rvalid` is nonzero, otherwise 0.
- **Collision**: a granted read and a granted write to the same address in the same cycle; handling depends on the Configuration macro.
- **Reset**
  - `rptr` = `wptr` = 0, `o_rvalid` = 0, `o_rdata` = 0, forward register = 0.
  - Grant outputs and RF commands are 0 while `i_rst` is high, regardless of requests.
  - A read granted in the cycle before reset asserts produces no `o_rvalid`.

## Timing
- Grant: 0 cycles from request (combinational).
- Read data: `o_rvalid` and `o_rdata` appear exactly 1 cycle after `o_rgnt`.
- Write: committed at the RF on the grant edge.
- Throughput: one read and one write per cycle; back-to-back grants to the same requester are allowed when it is the only one requesting.
- Fairness: a continuously asserted request is granted within `NREQ` cycles.
- No combinational path from `i_rf_rdata` to any grant.

## Configuration
- **`RF2P_ARB_FWD_EN` defined**
  - On a collision, both read and write are granted.
  - The write data is captured into a forward register.
  - The next cycle, `o_rdata` = the forwarded write data instead of `i_rf_rdata` (read returns the new value).
  - `o_rf_read` is still issued.
- **Undefined**
  - On a collision, the read grant is withheld and the write proceeds.
  - `rptr` does not advance; the read requester retries next cycle and sees the new value.

## Test plan
- **Reset**: assert `i_rst` with all requests high → all grants, `o_rvalid` and `o_rdata` are 0. After release, requester 0 is granted first on both ports.
- **Round-robin**: all 4 `i_rreq` held high for 8 cycles → `o_rgnt` = 0001, 0010, 0100, 1000, 0001 …; `o_rvalid` follows the same sequence, lagging by 1 cycle.
- **Data path**:
  - Requester 2 writes 0xBEEF to address 7.
  - Two cycles later, requester 1 reads address 7.
  - Next cycle → `o_rvalid` = 0010 and `o_rdata` = 0xBEEF.
- **Collision**: address 3 holds 0x1111; requester 0 reads address 3 while requester 1 writes 0x2222 to address 3 in the same cycle.
  - With `RF2P_ARB_FWD_EN` → read granted; the next cycle returns 0x2222.
  - Without it → read stalled one cycle, then granted; returns 0x2222.
- **Reset mid-read**: grant a read in cycle N, assert `i_rst` in cycle N+1 → `o_rvalid` stays 0 and `rptr` returns to 0.
- **Independence**: requester 3 writes every cycle while requesters 0–2 read every cycle → the write port grants 1000 every cycle, and the reads rotate among 0–2 unaffected.

Source files
------------

// File: rtl/rf2p_arbiter.sv
// rtl/rf2p_arbiter.sv - round-robin read/write port arbiter for one two-port register file; optional RF2P_ARB_FWD_EN enables collision forwarding
module rf2p_arbiter #(
  parameter int NREQ = 4,
  parameter int DWd  = 16,
  parameter int AWd  = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NREQ-1:0]      i_rreq,
  input  logic [NREQ*AWd-1:0]  i_raddr,
  output logic [NREQ-1:0]      o_rgnt,
  output logic [NREQ-1:0]      o_rvalid,
  output logic [DWd-1:0]       o_rdata,
  input  logic [NREQ-1:0]      i_wreq,
  input  logic [NREQ*AWd-1:0]  i_waddr,
  input  logic [NREQ*DWd-1:0]  i_wdata,
  output logic [NREQ-1:0]      o_wgnt,
  output logic                 o_rf_read,
  output logic [AWd-1:0]       o_rf_raddr,
  input  logic [DWd-1:0]       i_rf_rdata,
  output logic                 o_rf_write,
  output logic [AWd-1:0]       o_rf_waddr,
  output logic [DWd-1:0]       o_rf_wdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rptr;
  logic [PW-1:0]   wptr;
  logic [NREQ-1:0] rvalid_q;

  logic            rwin_valid;
  logic [PW-1:0]   rwin_idx;
  logic            wwin_valid;
  logic [PW-1:0]   wwin_idx;

  logic [AWd-1:0]  raddr_win;
  logic [AWd-1:0]  waddr_win;
  logic [DWd-1:0]  wdata_win;

  logic            collision;
  logic            rgrant_ok;
  logic            wgrant_ok;

`ifdef RF2P_ARB_FWD_EN
  logic            fwd_sel_q;
  logic [DWd-1:0]  fwd_data_q;
`endif

  // First asserted request at or after ptr, wrapping; returns {found, index}.
  // Every bit select uses a loop constant so the search unrolls into a flat
  // priority network without variable indexing.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] req,
                                          input logic [PW-1:0]   ptr);
    logic          found;
    logic [PW-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req[j] && (((int'(ptr) + i) % NREQ) == j)) begin
          found = 1'b1;
          win   = PW'(j);
        end
      end
    end
    return {found, win};
  endfunction

  // Pointer advance: one past the winner, wrapping after the last requester.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] idx);
    return (idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1);
  endfunction

  // Independent round-robin search on the read and write request vectors.
  always_comb begin
    {rwin_valid, rwin_idx} = rr_pick(i_rreq, rptr);
    {wwin_valid, wwin_idx} = rr_pick(i_wreq, wptr);
  end

  // Select the winning requesters' address and data fields.
  always_comb begin
    raddr_win = '0;
    waddr_win = '0;
    wdata_win = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (rwin_idx == PW'(j)) raddr_win = i_raddr[j*AWd +: AWd];
      if (wwin_idx == PW'(j)) begin
        waddr_win = i_waddr[j*AWd +: AWd];
        wdata_win = i_wdata[j*DWd +: DWd];
      end
    end
  end

  // Collision detection and final grant qualification; reset forces no grants.
  always_comb begin
    collision = rwin_valid && wwin_valid && (raddr_win == waddr_win);
    wgrant_ok = wwin_valid && !i_rst;
`ifdef RF2P_ARB_FWD_EN
    // Both sides proceed; the read picks up the new value from the forward register.
    rgrant_ok = rwin_valid && !i_rst;
`else
    // Hold the read off one cycle so it retries after the write has landed.
    rgrant_ok = rwin_valid && !collision && !i_rst;
`endif
  end

  // One-hot grants and RF command outputs; address/data are zero with no grant.
  always_comb begin
    o_rgnt = '0;
    o_wgnt = '0;
    for (int j = 0; j < NREQ; j++) begin
      o_rgnt[j] = rgrant_ok && (rwin_idx == PW'(j));
      o_wgnt[j] = wgrant_ok && (wwin_idx == PW'(j));
    end
    o_rf_read  = rgrant_ok;
    o_rf_raddr = rgrant_ok ? raddr_win : '0;
    o_rf_write = wgrant_ok;
    o_rf_waddr = wgrant_ok ? waddr_win : '0;
    o_rf_wdata = wgrant_ok ? wdata_win : '0;
  end

  // Round-robin pointers move only when their port actually grants.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rptr <= '0;
      wptr <= '0;
    end else begin
      if (rgrant_ok) rptr <= ptr_next(rwin_idx);
      if (wgrant_ok) wptr <= ptr_next(wwin_idx);
    end
  end

  // Register the read winner so its valid lines up with the RF read data.
  always_ff @(posedge i_clk) begin
    if (i_rst) rvalid_q <= '0;
    else       rvalid_q <= o_rgnt;
  end

`ifdef RF2P_ARB_FWD_EN
  // Capture colliding write data so the paired read returns the new value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fwd_sel_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_sel_q <= collision && rgrant_ok && wgrant_ok;
      if (collision && rgrant_ok && wgrant_ok) fwd_data_q <= wdata_win;
    end
  end
`endif

  // Returned data is zero unless a valid is showing; a valid captured just
  // before reset asserts is suppressed while reset is high.
  always_comb begin
    o_rvalid = i_rst ? '0 : rvalid_q;
    o_rdata  = '0;
    if (|o_rvalid) begin
`ifdef RF2P_ARB_FWD_EN
      o_rdata = fwd_sel_q ? fwd_data_q : i_rf_rdata;
`else
      o_rdata = i_rf_rdata;
`endif
    end
  end

endmodule

// File: tb/tb_rf2p_arbiter.sv
// tb/tb_rf2p_arbiter.sv - directed self-checking bench for rf2p_arbiter with a behavioural RF2P model
module tb_rf2p_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int AW   = 5;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    rreq;
  logic [NREQ*AW-1:0] raddr_flat;
  logic [NREQ-1:0]    rgnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic [NREQ-1:0]    wreq;
  logic [NREQ*AW-1:0] waddr_flat;
  logic [NREQ*DW-1:0] wdata_flat;
  logic [NREQ-1:0]    wgnt;
  logic               rf_read;
  logic [AW-1:0]      rf_raddr;
  logic [DW-1:0]      rf_rdata;
  logic               rf_write;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;

  logic [AW-1:0] raddr_a [NREQ];
  logic [AW-1:0] waddr_a [NREQ];
  logic [DW-1:0] wdata_a [NREQ];
  logic [DW-1:0] mem [32];

  int total;
  int passed;

  for (genvar g = 0; g < NREQ; g++) begin : g_flat
    assign raddr_flat[g*AW +: AW] = raddr_a[g];
    assign waddr_flat[g*AW +: AW] = waddr_a[g];
    assign wdata_flat[g*DW +: DW] = wdata_a[g];
  end

  rf2p_arbiter #(.NREQ(NREQ), .DWd(DW), .AWd(AW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rreq     (rreq),
    .i_raddr    (raddr_flat),
    .o_rgnt     (rgnt),
    .o_rvalid   (rvalid),
    .o_rdata    (rdata),
    .i_wreq     (wreq),
    .i_waddr    (waddr_flat),
    .i_wdata    (wdata_flat),
    .o_wgnt     (wgnt),
    .o_rf_read  (rf_read),
    .o_rf_raddr (rf_raddr),
    .i_rf_rdata (rf_rdata),
    .o_rf_write (rf_write),
    .o_rf_waddr (rf_waddr),
    .o_rf_wdata (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RF2P model: read returns the pre-write contents, one cycle after the command.
  always @(posedge clk) begin
    if (rf_read)  rf_rdata <= mem[rf_raddr];
    if (rf_write) mem[rf_waddr] <= rf_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rreq = '0;
    wreq = '0;
    for (int i = 0; i < NREQ; i++) begin
      raddr_a[i] = '0;
      waddr_a[i] = '0;
      wdata_a[i] = '0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    for (int i = 0; i < NREQ; i++) begin
      raddr_a[i] = AW'(i);
      waddr_a[i] = AW'(i + 8);
      wdata_a[i] = DW'(16'h0A00 + i);
    end
    rreq = '1;
    wreq = '1;
    rst  = 1'b1;
    tick();
    tick();
    #2;
    total++; if (rgnt !== 4'b0000) $display("FAIL reset_rgnt: got %b expected 0000", rgnt); else passed++;
    total++; if (wgnt !== 4'b0000) $display("FAIL reset_wgnt: got %b expected 0000", wgnt); else passed++;
    total++; if (rvalid !== 4'b0000) $display("FAIL reset_rvalid: got %b expected 0000", rvalid); else passed++;
    total++; if (rdata !== 16'h0000) $display("FAIL reset_rdata: got %h expected 0000", rdata); else passed++;
    total++; if ({rf_read, rf_write} !== 2'b00) $display("FAIL reset_rf_cmd: got %b expected 00", {rf_read, rf_write}); else passed++;
    rst = 1'b0;
    #2;
    total++; if (rgnt !== 4'b0001) $display("FAIL reset_first_rgnt: got %b expected 0001", rgnt); else passed++;
    total++; if (wgnt !== 4'b0001) $display("FAIL reset_first_wgnt: got %b expected 0001", wgnt); else passed++;
    tick();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_g;
    logic [NREQ-1:0] exp_v;
    do_reset();
    for (int i = 0; i < NREQ; i++) raddr_a[i] = AW'(i + 1);
    rreq  = '1;
    exp_v = '0;
    for (int c = 0; c < 8; c++) begin
      exp_g = 4'b0001 << (c % 4);
      #2;
      total++; if (rgnt !== exp_g) $display("FAIL rr_rgnt c%0d: got %b expected %b", c, rgnt, exp_g); else passed++;
      total++; if (rvalid !== exp_v) $display("FAIL rr_rvalid c%0d: got %b expected %b", c, rvalid, exp_v); else passed++;
      exp_v = exp_g;
      tick();
    end
    clear_inputs();
    #2;
    total++; if (rvalid !== exp_v) $display("FAIL rr_rvalid_last: got %b expected %b", rvalid, exp_v); else passed++;
    tick();
  endtask

  task automatic test_data_path();
    do_reset();
    wreq = 4'b0100;
    waddr_a[2] = 5'd7;
    wdata_a[2] = 16'hBEEF;
    #2;
    total++; if (wgnt !== 4'b0100) $display("FAIL dp_wgnt: got %b expected 0100", wgnt); else passed++;
    total++; if ({rf_write, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 16'hBEEF})
      $display("FAIL dp_rf_write: got %b/%0d/%h expected 1/7/beef", rf_write, rf_waddr, rf_wdata); else passed++;
    tick();
    clear_inputs();
    tick();
    rreq = 4'b0010;
    raddr_a[1] = 5'd7;
    #2;
    total++; if (rgnt !== 4'b0010) $display("FAIL dp_rgnt: got %b expected 0010", rgnt); else passed++;
    total++; if (rf_raddr !== 5'd7) $display("FAIL dp_rf_raddr: got %0d expected 7", rf_raddr); else passed++;
    tick();
    clear_inputs();
    #2;
    total++; if (rvalid !== 4'b0010) $display("FAIL dp_rvalid: got %b expected 0010", rvalid); else passed++;
    total++; if (rdata !== 16'hBEEF) $display("FAIL dp_rdata: got %h expected beef", rdata); else passed++;
    tick();
  endtask

  task automatic test_collision();
    do_reset();
    wreq = 4'b0010;
    waddr_a[1] = 5'd3;
    wdata_a[1] = 16'h1111;
    tick();
    clear_inputs();
    rreq = 4'b0001;
    raddr_a[0] = 5'd3;
    wreq = 4'b0010;
    waddr_a[1] = 5'd3;
    wdata_a[1] = 16'h2222;
    #2;
`ifdef RF2P_ARB_FWD_EN
    total++; if (rgnt !== 4'b0001) $display("FAIL col_rgnt: got %b expected 0001", rgnt); else passed++;
    total++; if (wgnt !== 4'b0010) $display("FAIL col_wgnt: got %b expected 0010", wgnt); else passed++;
    tick();
    clear_inputs();
    #2;
`else
    total++; if (rgnt !== 4'b0000) $display("FAIL col_rgnt_stall: got %b expected 0000", rgnt); else passed++;
    total++; if (wgnt !== 4'b0010) $display("FAIL col_wgnt: got %b expected 0010", wgnt); else passed++;
    tick();
    wreq = '0;
    #2;
    total++; if (rvalid !== 4'b0000) $display("FAIL col_rvalid_stall: got %b expected 0000", rvalid); else passed++;
    total++; if (rgnt !== 4'b0001) $display("FAIL col_rgnt_retry: got %b expected 0001", rgnt); else passed++;
    tick();
    clear_inputs();
    #2;
`endif
    total++; if (rvalid !== 4'b0001) $display("FAIL col_rvalid: got %b expected 0001", rvalid); else passed++;
    total++; if (rdata !== 16'h2222) $display("FAIL col_rdata: got %h expected 2222", rdata); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    rreq = 4'b0001;
    raddr_a[0] = 5'd1;
    tick();
    rreq = 4'b0100;
    raddr_a[2] = 5'd5;
    #2;
    total++; if (rgnt !== 4'b0100) $display("FAIL rst_mid_rgnt: got %b expected 0100", rgnt); else passed++;
    tick();
    clear_inputs();
    rst = 1'b1;
    #2;
    total++; if (rvalid !== 4'b0000) $display("FAIL rst_mid_rvalid: got %b expected 0000", rvalid); else passed++;
    total++; if (rdata !== 16'h0000) $display("FAIL rst_mid_rdata: got %h expected 0000", rdata); else passed++;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) raddr_a[i] = AW'(i + 10);
    rreq = '1;
    #2;
    total++; if (rgnt !== 4'b0001) $display("FAIL rst_mid_rptr: got %b expected 0001", rgnt); else passed++;
    total++; if (rvalid !== 4'b0000) $display("FAIL rst_mid_rvalid_after: got %b expected 0000", rvalid); else passed++;
    tick();
    clear_inputs();
  endtask

  task automatic test_independence();
    logic [NREQ-1:0] exp_g;
    do_reset();
    wreq = 4'b1000;
    waddr_a[3] = 5'd20;
    wdata_a[3] = 16'h5A5A;
    rreq = 4'b0111;
    for (int i = 0; i < 3; i++) raddr_a[i] = AW'(i);
    for (int c = 0; c < 6; c++) begin
      exp_g = 4'b0001 << (c % 3);
      #2;
      total++; if (wgnt !== 4'b1000) $display("FAIL ind_wgnt c%0d: got %b expected 1000", c, wgnt); else passed++;
      total++; if (rgnt !== exp_g) $display("FAIL ind_rgnt c%0d: got %b expected %b", c, rgnt, exp_g); else passed++;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    rst      = 1'b1;
    rf_rdata = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    clear_inputs();
    tick();
    test_reset();
    test_round_robin();
    test_data_path();
    test_collision();
    test_reset_mid_read();
    test_independence();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
